// File: rtl/ula_sequencer.sv
// ula_sequencer: round-robin scheduler granting the shared ALU to two masters.
// Registers the ALU inputs, waits LAT edges, then returns result as a pulse.
module ula_sequencer #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 5,
    parameter int LAT    = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [OP_W-1:0]   req1_op,
    output logic [1:0]        resp_valid,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_zero,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_zero,
    output logic              busy
);

    localparam logic [OP_W-1:0] OP_CMP   = OP_W'(5'b00010);
    localparam logic [OP_W-1:0] OP_ZEROS = OP_W'(5'b10000);
    localparam logic [2:0]      CNT_LAT  = 3'(LAT);

    typedef enum logic {
        IDLE,
        EXEC
    } state_t;

    state_t     state;
    logic [2:0] cnt;
    logic       owner;
    logic       last_grant;
    logic       grant;
    logic       accept;

    // On a tie the master that did not win last time gets the ALU.
    always_comb begin
        grant = 1'b0;
        unique case (req_valid)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            2'b11:   grant = ~last_grant;
            default: grant = 1'b0;
        endcase
    end

    always_comb begin
        req_ready = 2'b00;
        if (state == IDLE && req_valid != 2'b00) begin
            req_ready = grant ? 2'b10 : 2'b01;
        end
    end

    assign accept = |(req_valid & req_ready);
    assign busy   = (state == EXEC);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= 3'd0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            resp_valid <= 2'b00;
            resp_data  <= '0;
            resp_zero  <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= OP_ZEROS;
        end else begin
            resp_valid <= 2'b00;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        alu_a      <= grant ? req1_a  : req0_a;
                        alu_b      <= grant ? req1_b  : req0_b;
                        alu_op     <= grant ? req1_op : req0_op;
                        owner      <= grant;
                        last_grant <= grant;
                        cnt        <= CNT_LAT;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        resp_data  <= alu_out;
                        resp_zero  <= (alu_op == OP_CMP) && alu_zero;
                        resp_valid <= owner ? 2'b10 : 2'b01;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
